// File: rtl/nes_joypad_shifter.sv
// NES $4016/$4017 controller shift registers: strobe latch, live load, 1-filled serial shift.
// Optional JOYPAD_TURBO_EN adds turbo1/turbo2 ports that pulse A/B at TURBO_PERIOD half-period.
module nes_joypad_shifter #(
   parameter logic [6:0]  OPEN_BUS_HI  = 7'h20,
   parameter logic [23:0] TURBO_PERIOD = 24'd400000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_strobe,
   input  logic       wr_data,
   input  logic       rd_p1,
   input  logic       rd_p2,
   input  logic [7:0] buttons1,
   input  logic [7:0] buttons2,
`ifdef JOYPAD_TURBO_EN
   input  logic [1:0] turbo1,
   input  logic [1:0] turbo2,
`endif
   output logic [7:0] dout1,
   output logic [7:0] dout2,
   output logic       strobe
);

   logic [7:0] sr1, sr2;
   logic [7:0] eff1, eff2;

   if (TURBO_PERIOD == 24'd0) begin : g_period_check
      $error("TURBO_PERIOD must be nonzero");
   end

`ifdef JOYPAD_TURBO_EN
   logic [23:0] turbo_cnt;
   logic        turbo_phase;

   // Free-running: turbo cadence does not depend on when the game strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         turbo_cnt   <= '0;
         turbo_phase <= 1'b0;
      end else if (turbo_cnt == TURBO_PERIOD - 24'd1) begin
         turbo_cnt   <= '0;
         turbo_phase <= ~turbo_phase;
      end else begin
         turbo_cnt <= turbo_cnt + 24'd1;
      end
   end

   always_comb begin
      eff1      = buttons1;
      eff2      = buttons2;
      eff1[1:0] = buttons1[1:0] | (turbo1 & {2{turbo_phase}});
      eff2[1:0] = buttons2[1:0] | (turbo2 & {2{turbo_phase}});
   end
`else
   always_comb begin
      eff1 = buttons1;
      eff2 = buttons2;
   end
`endif

   // Load/shift decisions use the registered strobe, so a same-cycle write only
   // affects behaviour from the following cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         strobe <= 1'b0;
         sr1    <= '0;
         sr2    <= '0;
      end else begin
         if (wr_strobe)
            strobe <= wr_data;

         if (strobe)
            sr1 <= eff1;
         else if (rd_p1)
            sr1 <= {1'b1, sr1[7:1]};

         if (strobe)
            sr2 <= eff2;
         else if (rd_p2)
            sr2 <= {1'b1, sr2[7:1]};
      end
   end

   always_comb begin
      dout1 = {OPEN_BUS_HI, sr1[0]};
      dout2 = {OPEN_BUS_HI, sr2[0]};
   end

endmodule
